uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter CLOCKS_PER_BAUD, default 104, giving clocks per bit period (115200 baud at 12 MHz); legal range 8..65535.
REQ-002 The block SHALL have port clk_i, input, 1 bit: the single clock, with all logic on its rising edge.
REQ-003 The block SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-004 The block SHALL have port rx_i, input, 1 bit: serial line, asynchronous to clk_i, idle high.
REQ-005 The block SHALL have port data_o, output, 8 bits: last correctly framed byte.
REQ-006 The block SHALL have port valid_o, output, 1 bit: one-cycle pulse when data_o is updated.
REQ-007 The block SHALL have port frame_err_o, output, 1 bit: one-cycle pulse when the stop bit is sampled low.
REQ-008 The block SHALL have port busy_o, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-009 The frame format SHALL be 8N1: start bit 0, 8 data bits LSB first, 1 stop bit 1; no parity.
REQ-010 rx_i SHALL pass through a 2-flop synchronizer initialised to 1; the FSM SHALL use only the synchronized value rxs.
REQ-011 FSM states SHALL be IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-012 IDLE->START SHALL occur on rxs=0 (cycle T), loading the baud counter with H = CLOCKS_PER_BAUD/2 (integer division).
REQ-013 In START, at T+H, rxs=1 SHALL be treated as a false start: return to IDLE with no output pulse; rxs=0 SHALL enter DATA.
REQ-014 Data bit i (i=0..7) SHALL be sampled at T+H+(i+1)*CLOCKS_PER_BAUD into shift register bit i; the bit counter SHALL be 3 bits wide and wrap from 7 to exit DATA.
REQ-015 The stop bit SHALL be sampled at T+H+9*CLOCKS_PER_BAUD.
REQ-016 If the stop bit is 1: data_o SHALL load the shift register and valid_o SHALL pulse for exactly one cycle at T+H+9*CLOCKS_PER_BAUD+1, and the FSM SHALL return to IDLE in that same cycle.
REQ-017 If the stop bit is 0: frame_err_o SHALL pulse for exactly one cycle at the same relative time, data_o SHALL hold its old value, valid_o SHALL stay low, and the FSM SHALL enter WAIT_IDLE.
REQ-018 WAIT_IDLE SHALL go to IDLE on the first cycle rxs=1; a held-low line (break) SHALL produce exactly one frame_err_o pulse.
REQ-019 A start edge arriving immediately after the stop-bit sample (zero idle gap) SHALL be accepted: IDLE SHALL detect it on the cycle after returning.
REQ-020 valid_o and frame_err_o SHALL never be high in the same cycle.
REQ-021 data_o SHALL remain stable between valid_o pulses.
REQ-022 The baud counter SHALL count down to 0 and reload, be $clog2(CLOCKS_PER_BAUD+1) bits wide, and never underflow.
REQ-023 The block SHALL correctly receive frames whose bit period deviates up to ±3% from CLOCKS_PER_BAUD.

Reset
REQ-024 While rst_i=1, the block SHALL hold state=IDLE, synchronizer flops=1, shift register=0, data_o=8'h00, valid_o=0, frame_err_o=0, busy_o=0, and counters=0.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no valid_o or frame_err_o pulse.
REQ-026 After reset deassertion, a line already low SHALL be treated as a start edge and processed normally.

Structure
REQ-027 A shared include uart_defs.vh SHALL hold the CLOCKS_PER_BAUD_115200 (104) constant, the FSM state encodings and DATA_BITS (8); uart_tx SHALL use the same file.
REQ-028 The 2-flop synchronizer SHALL be a separate sub-module, sync2 (parameterised reset value), reusable across the codebase.
REQ-029 The remaining logic SHALL be a single FSM plus counters in uart_rx, with all outputs registered.

Verification
REQ-030 Send 0x41 at 104 clk/bit -> exactly one valid_o pulse with data_o=0x41 at the REQ-016 cycle, and frame_err_o stays 0.
REQ-031 Send back-to-back 0x00, 0xFF, 0x5A with zero idle gap -> three valid_o pulses, data_o=0x00, 0xFF, 0x5A in order.
REQ-032 Pulse rx_i low for 30 cycles, then return it high -> no valid_o or frame_err_o, and busy_o returns to 0 by cycle T+53.
REQ-033 Send 0x33 with the stop bit forced 0, hold the line low for 2000 cycles, then release it and send 0x7E -> exactly one frame_err_o pulse, data_o unchanged until 0x7E is received.
REQ-034 Assert rst_i during data bit 4 of a frame, release it, then send 0xC3 -> no pulse from the aborted frame, then data_o=0xC3 with valid_o.
REQ-035 Send 0xA5 at 101 and at 107 clk/bit with CLOCKS_PER_BAUD=104 -> data_o=0xA5 and valid_o in both cases.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: baud constant, data width and receiver FSM states.
package uart_rx_pkg;

    localparam int unsigned CLOCKS_PER_BAUD_115200 = 104;
    localparam int unsigned DATA_BITS              = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } uart_state_e;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous bit, with a selectable reset value.
module sync2 #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= RESET_VALUE;
            sync_q <= RESET_VALUE;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronized line, mid-bit sampling FSM, registered outputs.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLOCKS_PER_BAUD = CLOCKS_PER_BAUD_115200
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    output logic                 frame_err_o,
    output logic                 busy_o
);

    localparam int CNT_W = $clog2(CLOCKS_PER_BAUD + 1);
    localparam int BIT_W = $clog2(DATA_BITS);
    // The counter counts down through zero inclusive, so loads are one less than the wanted interval.
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLOCKS_PER_BAUD / 2 - 1);
    localparam logic [CNT_W-1:0] BAUD_LOAD = CNT_W'(CLOCKS_PER_BAUD - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);

    logic rxs;

    uart_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q,   cnt_d;
    logic [BIT_W-1:0]     bit_q,   bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q,  data_d;
    logic                 valid_q, valid_d;
    logic                 err_q,   err_d;
    logic                 busy_q,  busy_d;
    logic                 tick;

    sync2 #(
        .RESET_VALUE(1'b1)
    ) u_sync (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .d_i  (rx_i),
        .q_o  (rxs)
    );

    assign tick = (cnt_q == '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!rxs) begin
                    state_d = ST_START;
                    cnt_d   = HALF_LOAD;
                end
            end
            ST_START: begin
                if (!tick) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (rxs) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DATA;
                    cnt_d   = BAUD_LOAD;
                    bit_d   = '0;
                end
            end
            ST_DATA: begin
                if (!tick) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    shift_d[bit_q] = rxs;
                    cnt_d          = BAUD_LOAD;
                    bit_d          = bit_q + 1'b1;
                    if (bit_q == LAST_BIT) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (!tick) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (rxs) begin
                    data_d  = shift_q;
                    valid_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    err_d   = 1'b1;
                    state_d = ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                // A held-low break stays here so only one error pulse is raised.
                if (rxs) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = err_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Randomized scoreboard bench for uart_rx: frames are queued as expected results and a monitor checks every pulse.
module tb_uart_rx;

    localparam int C = 104;
    localparam int H = C / 2;

    typedef struct {
        bit         isErr;
        logic [7:0] data;
        int         expCycle;
    } expect_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] dataO;
    logic       validO;
    logic       errO;
    logic       busyO;

    int checks   = 0;
    int failures = 0;
    int cycCount = 0;

    expect_t sbQ[$];

    uart_rx #(
        .CLOCKS_PER_BAUD(C)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .rx_i       (rx),
        .data_o     (dataO),
        .valid_o    (validO),
        .frame_err_o(errO),
        .busy_o     (busyO)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycCount <= cycCount + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, actual, expected, cycCount);
        end
    endtask

    task automatic driveBit(input logic b, input int n);
        rx = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Queue the expected outcome, then serialize start, LSB-first data and stop bit.
    task automatic applyStimulus(input logic [7:0] d, input int period, input bit stopBit, input bit timed);
        expect_t e;
        e.isErr    = !stopBit;
        e.data     = d;
        e.expCycle = timed ? cycCount + 3 + H + 9 * C : -1;
        sbQ.push_back(e);
        driveBit(1'b0, period);
        for (int k = 0; k < 8; k++) driveBit(d[k], period);
        driveBit(stopBit, period);
    endtask

    // Monitor: pops an expectation for every pulse, and watches data_o stability.
    logic [7:0] lastGood = 8'h00;
    logic [7:0] prevData = 8'h00;
    expect_t    mon;

    always @(negedge clk) begin
        if (rst) begin
            lastGood = 8'h00;
        end else begin
            if (validO && errO) begin
                checkOutput("valid_err_overlap", 32'(validO & errO), 32'd0);
            end
            if (validO || errO) begin
                if (sbQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_pulse: got valid=%0b err=%0b expected no pulse at cycle %0d",
                             validO, errO, cycCount);
                end else begin
                    mon = sbQ.pop_front();
                    checkOutput("pulse_kind_err", 32'(errO), 32'(mon.isErr));
                    if (mon.isErr) begin
                        checkOutput("data_held_on_err", 32'(dataO), 32'(lastGood));
                    end else begin
                        checkOutput("data", 32'(dataO), 32'(mon.data));
                        lastGood = mon.data;
                    end
                    if (mon.expCycle >= 0) begin
                        checkOutput("pulse_cycle", 32'(cycCount), 32'(mon.expCycle));
                    end
                end
            end else if (dataO !== prevData) begin
                checkOutput("data_stable", 32'(dataO), 32'(prevData));
            end
        end
        prevData = dataO;
    end

    initial begin
        logic [7:0] d;
        int         period;
        bit         stopBit;
        int         gap;

        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_data", 32'(dataO), 32'd0);
        checkOutput("reset_valid", 32'(validO), 32'd0);
        checkOutput("reset_err", 32'(errO), 32'd0);
        checkOutput("reset_busy", 32'(busyO), 32'd0);
        rst = 1'b0;
        driveBit(1'b1, 5);

        // Single frame with exact timing.
        applyStimulus(8'h41, C, 1'b1, 1'b1);
        driveBit(1'b1, 20);

        // Back-to-back frames with no idle gap.
        applyStimulus(8'h00, C, 1'b1, 1'b1);
        applyStimulus(8'hFF, C, 1'b1, 1'b1);
        applyStimulus(8'h5A, C, 1'b1, 1'b1);
        driveBit(1'b1, 20);

        // Glitch shorter than half a bit must be rejected.
        driveBit(1'b0, 10);
        checkOutput("false_start_busy_high", 32'(busyO), 32'd1);
        driveBit(1'b0, 20);
        driveBit(1'b1, 30);
        checkOutput("false_start_busy_low", 32'(busyO), 32'd0);
        driveBit(1'b1, 20);

        // Bad stop bit followed by a long break, then a good frame.
        applyStimulus(8'h33, C, 1'b0, 1'b1);
        driveBit(1'b0, 2000);
        checkOutput("break_busy", 32'(busyO), 32'd1);
        driveBit(1'b1, 50);
        checkOutput("data_after_break", 32'(dataO), 32'h5A);
        checkOutput("idle_after_break", 32'(busyO), 32'd0);
        applyStimulus(8'h7E, C, 1'b1, 1'b1);
        driveBit(1'b1, 20);

        // Reset during data bit 4 aborts the frame silently.
        driveBit(1'b0, C);
        for (int k = 0; k < 4; k++) driveBit(1'b1, C);
        driveBit(1'b0, H);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_data", 32'(dataO), 32'd0);
        checkOutput("abort_busy", 32'(busyO), 32'd0);
        checkOutput("abort_valid", 32'(validO), 32'd0);
        checkOutput("abort_err", 32'(errO), 32'd0);
        @(posedge clk);
        #1;
        driveBit(1'b1, 5);
        rst = 1'b0;
        driveBit(1'b1, 20);
        applyStimulus(8'hC3, C, 1'b1, 1'b1);
        driveBit(1'b1, 20);

        // Line already low when reset is released counts as a start edge.
        rx  = 1'b0;
        rst = 1'b1;
        driveBit(1'b0, 3);
        rst = 1'b0;
        applyStimulus(8'h96, C, 1'b1, 1'b1);
        driveBit(1'b1, 20);

        // Baud-rate tolerance at both ends.
        applyStimulus(8'hA5, 101, 1'b1, 1'b0);
        driveBit(1'b1, 20);
        applyStimulus(8'hA5, 107, 1'b1, 1'b0);
        driveBit(1'b1, 20);

        // Random frames, rates within tolerance and occasional framing errors.
        for (int n = 0; n < 20; n++) begin
            d       = 8'($urandom_range(0, 255));
            period  = int'($urandom_range(101, 107));
            stopBit = ($urandom_range(0, 4) != 0);
            applyStimulus(d, period, stopBit, period == C);
            gap = stopBit ? int'($urandom_range(0, 20)) : int'($urandom_range(10, 40));
            if (gap > 0) driveBit(1'b1, gap);
        end
        driveBit(1'b1, 20);

        for (int i = 0; i < 3000 && sbQ.size() != 0; i++) @(posedge clk);
        #1;
        checkOutput("queue_drained", 32'(sbQ.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
